count_seq_ctrl: RTL and testbench

COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

---
 rtl/count_seq_pkg.sv | 14 +
 rtl/count_seq_if.sv | 31 +++
 rtl/count_seq_core.sv | 43 ++++
 rtl/count_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_count_seq_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared state encoding and default width
// for the count sequencer.
package count_seq_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/count_seq_if.sv
// count_seq_if: control inputs and status outputs of the
// count sequencer, grouped with master/slave views.
interface count_seq_if #(
    parameter int WIDTH = count_seq_pkg::WIDTH_DEF
) ();

    logic             start;
    logic             stop;
    logic             pause;
    logic             auto_reload;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] term_val;
    logic [3:0]       prescale;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, stop, pause, auto_reload,
        output load_val, term_val, prescale,
        input  count, busy, done, state
    );

    modport slave (
        input  start, stop, pause, auto_reload,
        input  load_val, term_val, prescale,
        output count, busy, done, state
    );

endinterface

// File: rtl/count_seq_core.sv
// count_seq_core: count register with load/increment controls
// and a compare of the incremented value against the terminal.
module count_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] ld_val_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] term_i,
    output logic [WIDTH-1:0] count_o,
    output logic             hit_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] inc_val;

    assign inc_val = count_q + WIDTH'(1);
    assign hit_o   = (inc_val == term_i);
    assign count_o = count_q;

    // load wins over increment; otherwise hold
    always_comb begin
        count_d = count_q;
        if (ld_i) begin
            count_d = ld_val_i;
        end else if (inc_i) begin
            count_d = inc_val;
        end
    end

    // count register, synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: IDLE/RUN/PAUSE/DONE sequencer around the core.
// Optional tick prescaler enabled by COUNT_SEQ_PRESCALE_EN.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    count_seq_if.slave bus
);

    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic             rl_q, rl_d;
    logic             ar_q, ar_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             tick;
    logic             core_ld;
    logic             core_inc;
    logic [WIDTH-1:0] core_val;
    logic [WIDTH-1:0] count;
    logic             term_hit;

`ifdef COUNT_SEQ_PRESCALE_EN
    logic [3:0] ps_q, ps_d;
    logic [3:0] pc_q, pc_d;

    assign tick = (state_q == S_RUN) && (pc_q == ps_q);

    // prescaler: cleared on start, frozen outside RUN
    always_comb begin
        ps_d = ps_q;
        pc_d = pc_q;
        if (!bus.stop && bus.start) begin
            ps_d = bus.prescale;
            pc_d = '0;
        end else if (!bus.stop && state_q == S_RUN) begin
            pc_d = tick ? 4'd0 : pc_q + 4'd1;
        end
    end

    // prescaler registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_q <= '0;
            pc_q <= '0;
        end else begin
            ps_q <= ps_d;
            pc_q <= pc_d;
        end
    end
`else
    logic unused_prescale;
    assign unused_prescale = ^bus.prescale;
    assign tick = (state_q == S_RUN);
`endif

    count_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_i     (core_ld),
        .ld_val_i (core_val),
        .inc_i    (core_inc),
        .term_i   (term_q),
        .count_o  (count),
        .hit_o    (term_hit)
    );

    // next state: stop > start > pause; terminal handling on tick
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        rl_d     = rl_q;
        ar_d     = ar_q;
        load_d   = load_q;
        term_d   = term_q;
        core_ld  = 1'b0;
        core_inc = 1'b0;
        core_val = load_q;
        if (bus.stop) begin
            state_d = S_IDLE;
        end else if (bus.start) begin
            state_d  = S_RUN;
            ar_d     = bus.auto_reload;
            load_d   = bus.load_val;
            term_d   = bus.term_val;
            rl_d     = 1'b0;
            core_ld  = 1'b1;
            core_val = bus.load_val;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (bus.pause) begin
                        state_d = S_PAUSE;
                    end
                    if (tick && rl_q) begin
                        core_ld = 1'b1;
                        rl_d    = 1'b0;
                    end else if (tick) begin
                        core_inc = 1'b1;
                        if (term_hit) begin
                            done_d = 1'b1;
                            if (ar_q) begin
                                rl_d = 1'b1;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (!bus.pause) begin
                        state_d = S_RUN;
                    end
                end
                S_IDLE, S_DONE: ;
            endcase
        end
    end

    // control and captured-configuration registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            rl_q    <= 1'b0;
            ar_q    <= 1'b0;
            load_q  <= '0;
            term_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            rl_q    <= rl_d;
            ar_q    <= ar_d;
            load_q  <= load_d;
            term_q  <= term_d;
        end
    end

    assign bus.count = count;
    assign bus.busy  = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign bus.done  = done_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed and random checks of count_seq_ctrl
// against a cycle-level behavioural model.
module tb_count_seq_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    count_seq_if #(.WIDTH(W)) bus ();

    count_seq_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [1:0]   m_state;
    logic [W-1:0] m_count;
    logic [W-1:0] m_load;
    logic [W-1:0] m_term;
    logic         m_done;
    logic         m_ar;
    logic         m_reload;
    int           m_ps;
    int           m_elapsed;

    // model: runs in whole RUN cycles, ticks every (ps+1) of them
    task automatic model_edge();
        logic [1:0] nxt;
        if (!rst_n) begin
            m_state   = 2'd0;
            m_count   = '0;
            m_done    = 1'b0;
            m_load    = '0;
            m_term    = '0;
            m_ar      = 1'b0;
            m_ps      = 0;
            m_elapsed = 0;
            m_reload  = 1'b0;
        end else if (bus.stop) begin
            m_state = 2'd0;
            m_done  = 1'b0;
        end else if (bus.start) begin
            m_load = bus.load_val;
            m_term = bus.term_val;
            m_ar   = bus.auto_reload;
`ifdef COUNT_SEQ_PRESCALE_EN
            m_ps   = int'(bus.prescale);
`else
            m_ps   = 0;
`endif
            m_count   = bus.load_val;
            m_elapsed = 0;
            m_reload  = 1'b0;
            m_state   = 2'd1;
            m_done    = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_state == 2'd1) begin
                nxt = bus.pause ? 2'd2 : 2'd1;
                m_elapsed++;
                if (m_elapsed % (m_ps + 1) == 0) begin
                    if (m_reload) begin
                        m_count  = m_load;
                        m_reload = 1'b0;
                    end else begin
                        m_count = m_count + 8'd1;
                        if (m_count == m_term) begin
                            m_done = 1'b1;
                            if (m_ar) m_reload = 1'b1;
                            else nxt = 2'd3;
                        end
                    end
                end
                m_state = nxt;
            end else if (m_state == 2'd2 && !bus.pause) begin
                m_state = 2'd1;
            end
        end
    endtask

    function automatic logic [W+3:0] exp_vec();
        return {m_count, m_state, m_done,
                (m_state == 2'd1) || (m_state == 2'd2)};
    endfunction

    function automatic logic [W+3:0] obs_vec();
        return {bus.count, bus.state, bus.done, bus.busy};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic start_run(input logic [W-1:0] ld,
                             input logic [W-1:0] tm,
                             input logic ar,
                             input logic [3:0] ps);
        bus.load_val    = ld;
        bus.term_val    = tm;
        bus.auto_reload = ar;
        bus.prescale    = ps;
        bus.stop        = 1'b0;
        bus.pause       = 1'b0;
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++;
        if (obs_vec() !== '0) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", obs_vec(), 12'h0);
        end
        rst_n = 1'b1;
        start_run(8'h20, 8'h80, 1'b0, 4'd0);
        repeat (3) step();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.start = (i == 0);
            step();
            total++;
            if (bus.done !== 1'b0 || obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reset_midrun: got %h want %h", obs_vec(), exp_vec());
            end
        end
        bus.start = 1'b0;
        rst_n = 1'b1;
        step();
        total++;
        if (obs_vec() !== 12'h0) begin
            bad++;
            $display("FAIL reset_release: got %h want %h", obs_vec(), 12'h0);
        end
    endtask

    task automatic test_one_shot();
        logic [W-1:0] seq [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h13, 8'h13};
        start_run(8'h10, 8'h13, 1'b0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (obs_vec() !== exp_vec() || bus.count !== seq[i] ||
                bus.done !== (i == 3)) begin
                bad++;
                $display("FAIL one_shot[%0d]: got %h want %h cnt %h",
                         i, obs_vec(), exp_vec(), seq[i]);
            end
            step();
        end
        total++;
        if (bus.state !== 2'd3 || bus.count !== 8'h13) begin
            bad++;
            $display("FAIL one_shot_end: got %h/%h want 3/13", bus.state, bus.count);
        end
    endtask

    task automatic test_auto_reload();
        logic [W-1:0] seq [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        start_run(8'hFE, 8'h01, 1'b1, 4'd0);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (obs_vec() !== exp_vec() || bus.count !== seq[i % 4] ||
                bus.done !== (i % 4 == 3)) begin
                bad++;
                $display("FAIL auto_reload[%0d]: got %h want %h cnt %h",
                         i, obs_vec(), exp_vec(), seq[i % 4]);
            end
            bus.load_val    = W'($urandom);
            bus.term_val    = W'($urandom);
            bus.auto_reload = 1'($urandom);
            bus.prescale    = 4'($urandom);
            step();
        end
    endtask

    task automatic test_pause_stop();
        start_run(8'h00, 8'hF0, 1'b0, 4'd0);
        repeat (4) step();
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs_vec() !== exp_vec() || bus.count !== 8'h05 ||
                bus.state !== 2'd2) begin
                bad++;
                $display("FAIL pause_hold[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        bus.pause = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL pause_resume[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        step();
        total++;
        if (obs_vec() !== exp_vec() || bus.count !== 8'h07 ||
            bus.state !== 2'd0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL stop_idle: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_priority();
        start_run(8'h30, 8'h90, 1'b0, 4'd0);
        step();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        total++;
        if (obs_vec() !== exp_vec() || bus.state !== 2'd0) begin
            bad++;
            $display("FAIL prio_stop: got %h want %h", obs_vec(), exp_vec());
        end
        bus.load_val = 8'h44;
        bus.start    = 1'b1;
        bus.pause    = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        total++;
        if (obs_vec() !== exp_vec() || bus.state !== 2'd1 ||
            bus.count !== 8'h44) begin
            bad++;
            $display("FAIL prio_start: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_terminal_pause();
        start_run(8'h10, 8'h12, 1'b0, 4'd0);
        step();
        bus.pause = 1'b1;
        step();
        bus.pause = 1'b0;
        total++;
        if (obs_vec() !== exp_vec() || bus.done !== 1'b1 ||
            bus.state !== 2'd3 || bus.count !== 8'h12) begin
            bad++;
            $display("FAIL term_pause: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_full_wrap();
        logic [W-1:0] ld;
        int n;
        ld = W'($urandom);
        start_run(ld, ld, 1'b0, 4'd0);
        n = 0;
        while (n < 300 && bus.done !== 1'b1) begin
            step();
            n++;
        end
        total++;
        if (n !== 256 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL full_wrap: got %0d cycles %h want 256 %h", n, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_prescale();
        int n;
        int n_exp;
`ifdef COUNT_SEQ_PRESCALE_EN
        n_exp = 8;
`else
        n_exp = 2;
`endif
        start_run(8'h00, 8'h02, 1'b0, 4'd3);
        n = 0;
        while (n < 40 && bus.done !== 1'b1) begin
            step();
            n++;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL prescale[%0d]: got %h want %h", n, obs_vec(), exp_vec());
            end
        end
        total++;
        if (n !== n_exp) begin
            bad++;
            $display("FAIL prescale_done: got %0d want %0d", n, n_exp);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ld;
        for (int i = 0; i < 3000; i++) begin
            ld = W'($urandom);
            bus.stop        = ($urandom_range(0, 99) < 3);
            bus.start       = ($urandom_range(0, 99) < 5);
            bus.pause       = ($urandom_range(0, 99) < 20);
            bus.load_val    = ld;
            bus.term_val    = ld + W'($urandom_range(1, 6));
            bus.auto_reload = 1'($urandom);
            bus.prescale    = 4'($urandom_range(0, 3));
            rst_n           = ($urandom_range(0, 199) != 0);
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        rst_n     = 1'b1;
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.pause       = 1'b0;
        bus.auto_reload = 1'b0;
        bus.load_val    = '0;
        bus.term_val    = '0;
        bus.prescale    = '0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause_stop();
        test_priority();
        test_terminal_pause();
        test_full_wrap();
        test_prescale();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
